// File: rtl/div16x8_seq_if.sv
// Request/result bundle for the 16/8 sequential divider.
// The requester drives start and the operands; the divider drives results and status.
interface div16x8_seq_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done_flag, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done_flag, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/div16x8_seq.sv
// Restoring 16/8 unsigned divider, one quotient bit per cycle; done 9 cycles after accept (1 on error).
// No backpressure: start is sampled only in IDLE and dropped while busy; results hold until the next load.
module div16x8_seq (
  input logic          clk,
  input logic          reset_a,
  div16x8_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] divisor_q, divisor_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;

  logic [8:0] shifted;
  logic       trial_ok;

  // The partial remainder stays below the divisor, so its 9th bit only exists transiently in shifted.
  always_comb begin
    shifted     = {rem_q, shreg_q[7]};
    trial_ok    = (shifted >= {1'b0, divisor_q});
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisor_d = bus.divisor;
          dbz_d     = 1'b0;
          ovf_d     = 1'b0;
          if (bus.divisor == 8'h00) begin
            state_d     = DONE;
            dbz_d       = 1'b1;
            quotient_d  = 8'hFF;
            remainder_d = 8'h00;
          end else if (bus.dividend[15:8] >= bus.divisor) begin
            state_d     = DONE;
            ovf_d       = 1'b1;
            quotient_d  = 8'hFF;
            remainder_d = 8'h00;
          end else begin
            state_d = CALC;
            cnt_d   = 3'd0;
            rem_d   = bus.dividend[15:8];
            shreg_d = bus.dividend[7:0];
          end
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register.
        rem_d   = trial_ok ? 8'(shifted - {1'b0, divisor_q}) : shifted[7:0];
        shreg_d = {shreg_q[6:0], trial_ok};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = DONE;
          quotient_d  = shreg_d;
          remainder_d = rem_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      divisor_q   <= 8'h00;
      rem_q       <= 8'h00;
      shreg_q     <= 8'h00;
      quotient_q  <= 8'h00;
      remainder_q <= 8'h00;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.done_flag   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
